// File: rtl/fin_pkg.sv
// Shared types for the market-data message parser.
//   parser_state_e : parser FSM states
//   MSG_*          : accepted message-type bytes
//   fin_rec_t      : one parsed order record as presented downstream
package fin_pkg;

    localparam int unsigned BEAT_W = 64;

    localparam logic [7:0] MSG_ADD  = 8'h41;  // 'A'
    localparam logic [7:0] MSG_DEL  = 8'h44;  // 'D'
    localparam logic [7:0] MSG_EXEC = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        ST_HDR,
        ST_PRICE,
        ST_QTY,
        ST_EMIT,
        ST_DISCARD
    } parser_state_e;

    typedef struct packed {
        logic [7:0]  msg_type;
        logic        side;
        logic [15:0] symbol;
        logic [31:0] seq;
        logic [63:0] price;
        logic [31:0] qty;
        logic [31:0] order_id;
        logic        seq_gap;
    } fin_rec_t;

    function automatic logic is_valid_type(input logic [7:0] t);
        return (t == MSG_ADD) || (t == MSG_DEL) || (t == MSG_EXEC);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : rising-edge clock
//   rst   : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/axis_msg_parser.sv
// Parses 3-beat AXI-Stream order messages into one record per message.
//   clk, rst          : clock, synchronous active-high reset
//   s_tdata/tvalid/tlast/tready : upstream AXIS beat stream
//   m_valid/m_ready   : downstream record handshake
//   m_type..m_order_id: parsed record fields, held while m_valid && !m_ready
//   m_seq_gap         : record sequence number differs from the expected one
//   err_cnt           : saturating count of dropped messages
module axis_msg_parser
    import fin_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_type,
    output logic             m_side,
    output logic [15:0]      m_symbol,
    output logic [31:0]      m_seq,
    output logic [63:0]      m_price,
    output logic [31:0]      m_qty,
    output logic [31:0]      m_order_id,
    output logic             m_seq_gap,
    output logic [ERR_W-1:0] err_cnt
);

    generate
        if (WIDTH != BEAT_W) begin : g_width_check
            $error("axis_msg_parser: WIDTH must be 64");
        end
    endgenerate

    parser_state_e state;
    fin_rec_t      rec_q;

    logic [7:0]  hdr_type;
    logic        hdr_side;
    logic [15:0] hdr_symbol;
    logic [31:0] hdr_seq;
    logic [63:0] price_q;
    logic [31:0] expected_seq;
    logic        seen_first;

    logic accept_c;
    logic err_inc_c;
    logic unused_hdr_bits;

    assign accept_c        = s_tvalid && s_tready;
    assign unused_hdr_bits = ^s_tdata[55:49];

    // One drop event per message: bad type, early tlast, or missing tlast on beat2.
    always_comb begin
        err_inc_c = 1'b0;
        if (accept_c) begin
            case (state)
                ST_HDR:   err_inc_c = !is_valid_type(s_tdata[63:56]) || s_tlast;
                ST_PRICE: err_inc_c = s_tlast;
                ST_QTY:   err_inc_c = !s_tlast;
                default:  err_inc_c = 1'b0;
            endcase
        end
    end

    // Parser FSM with registered handshake outputs and record.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_HDR;
            s_tready     <= 1'b0;
            m_valid      <= 1'b0;
            rec_q        <= '0;
            hdr_type     <= '0;
            hdr_side     <= 1'b0;
            hdr_symbol   <= '0;
            hdr_seq      <= '0;
            price_q      <= '0;
            expected_seq <= '0;
            seen_first   <= 1'b0;
        end else begin
            s_tready <= 1'b1;
            case (state)
                ST_HDR: begin
                    if (accept_c) begin
                        if (!is_valid_type(s_tdata[63:56])) begin
                            state <= s_tlast ? ST_HDR : ST_DISCARD;
                        end else if (s_tlast) begin
                            state <= ST_HDR;
                        end else begin
                            hdr_type   <= s_tdata[63:56];
                            hdr_side   <= s_tdata[48];
                            hdr_symbol <= s_tdata[47:32];
                            hdr_seq    <= s_tdata[31:0];
                            state      <= ST_PRICE;
                        end
                    end
                end
                ST_PRICE: begin
                    if (accept_c) begin
                        if (s_tlast) begin
                            state <= ST_HDR;
                        end else begin
                            price_q <= s_tdata[63:0];
                            state   <= ST_QTY;
                        end
                    end
                end
                ST_QTY: begin
                    if (accept_c) begin
                        if (s_tlast) begin
                            rec_q.msg_type <= hdr_type;
                            rec_q.side     <= hdr_side;
                            rec_q.symbol   <= hdr_symbol;
                            rec_q.seq      <= hdr_seq;
                            rec_q.price    <= price_q;
                            rec_q.qty      <= s_tdata[63:32];
                            rec_q.order_id <= s_tdata[31:0];
                            rec_q.seq_gap  <= seen_first && (hdr_seq != expected_seq);
                            expected_seq   <= hdr_seq + 32'd1;
                            seen_first     <= 1'b1;
                            m_valid        <= 1'b1;
                            s_tready       <= 1'b0;
                            state          <= ST_EMIT;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end
                end
                ST_EMIT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= ST_HDR;
                    end else begin
                        s_tready <= 1'b0;
                    end
                end
                ST_DISCARD: begin
                    if (accept_c && s_tlast) begin
                        state <= ST_HDR;
                    end
                end
                default: state <= ST_HDR;
            endcase
        end
    end

    assign m_type     = rec_q.msg_type;
    assign m_side     = rec_q.side;
    assign m_symbol   = rec_q.symbol;
    assign m_seq      = rec_q.seq;
    assign m_price    = rec_q.price;
    assign m_qty      = rec_q.qty;
    assign m_order_id = rec_q.order_id;
    assign m_seq_gap  = rec_q.seq_gap;

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (err_inc_c),
        .count(err_cnt)
    );

endmodule

// File: tb/tb_axis_msg_parser.sv
// Scoreboard bench for axis_msg_parser: directed messages push expected
// records; a negedge monitor pops and compares on each downstream handshake.
module tb_axis_msg_parser;
    import fin_pkg::*;

    localparam int unsigned ERR_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [63:0]      s_tdata;
    logic             s_tvalid;
    logic             s_tlast;
    logic             s_tready;
    logic             m_valid;
    logic             m_ready;
    logic [7:0]       m_type;
    logic             m_side;
    logic [15:0]      m_symbol;
    logic [31:0]      m_seq;
    logic [63:0]      m_price;
    logic [31:0]      m_qty;
    logic [31:0]      m_order_id;
    logic             m_seq_gap;
    logic [ERR_W-1:0] err_cnt;

    axis_msg_parser #(
        .WIDTH(64),
        .ERR_W(ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_type    (m_type),
        .m_side    (m_side),
        .m_symbol  (m_symbol),
        .m_seq     (m_seq),
        .m_price   (m_price),
        .m_qty     (m_qty),
        .m_order_id(m_order_id),
        .m_seq_gap (m_seq_gap),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    fin_rec_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int tx_cnt   = 0;

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the presented record with the scoreboard head.
    always @(negedge clk) begin
        fin_rec_t got;
        if (!rst && m_valid) begin
            got.msg_type = m_type;
            got.side     = m_side;
            got.symbol   = m_symbol;
            got.seq      = m_seq;
            got.price    = m_price;
            got.qty      = m_qty;
            got.order_id = m_order_id;
            got.seq_gap  = m_seq_gap;
            if (exp_q.size() == 0) begin
                chk("unexpected_record", 192'(got), 192'(0));
            end else begin
                chk("record", 192'(got), 192'(exp_q[0]));
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    rx_cnt++;
                end else begin
                    chk("stall_tready", 192'(s_tready), 192'(0));
                end
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic last);
        int n;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        n = 0;
        while (!s_tready && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) chk("tready_timeout", 192'(0), 192'(1));
        tick();
    endtask

    task automatic send_msg(input logic [7:0] typ, input logic side, input logic [15:0] sym,
                            input logic [31:0] seq, input logic [63:0] price,
                            input logic [31:0] qty, input logic [31:0] id, input logic gap);
        fin_rec_t r;
        r.msg_type = typ;
        r.side     = side;
        r.symbol   = sym;
        r.seq      = seq;
        r.price    = price;
        r.qty      = qty;
        r.order_id = id;
        r.seq_gap  = gap;
        exp_q.push_back(r);
        tx_cnt++;
        send_beat({typ, 7'd0, side, sym, seq}, 1'b0);
        send_beat(price, 1'b0);
        send_beat({qty, id}, 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("drain_timeout", 192'(exp_q.size()), 192'(0));
        tick();
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int rx_before;
        int n;
        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_ready  = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_tready",  192'(s_tready), 192'(0));
        chk("rst_mvalid",  192'(m_valid),  192'(0));
        chk("rst_err",     192'(err_cnt),  192'(0));
        chk("rst_fields",  192'({m_type, m_side, m_symbol, m_seq, m_price, m_qty, m_order_id, m_seq_gap}), 192'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_tready", 192'(s_tready), 192'(1));

        // Basic record
        send_msg(8'h41, 1'b1, 16'h0123, 32'd5, 64'h0000_0000_0001_86A0, 32'd100, 32'd7, 1'b0);
        wait_idle();
        chk("basic_err", 192'(err_cnt), 192'(0));

        // Downstream stall for 5 cycles
        m_ready   = 1'b0;
        rx_before = rx_cnt;
        send_msg(8'h44, 1'b0, 16'h0BEE, 32'd6, 64'hFFFF_FFFF_FFFF_FF38, 32'd25, 32'd8, 1'b0);
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        chk("stall_mvalid", 192'(m_valid), 192'(1));
        repeat (5) tick();
        m_ready = 1'b1;
        wait_idle();
        repeat (3) tick();
        chk("stall_once", 192'(rx_cnt), 192'(rx_before + 1));

        // Sequence-gap tracking from a fresh reset
        do_reset();
        send_msg(8'h41, 1'b0, 16'h0001, 32'd10, 64'd1, 32'd1, 32'd1, 1'b0);
        send_msg(8'h41, 1'b0, 16'h0001, 32'd11, 64'd2, 32'd2, 32'd2, 1'b0);
        send_msg(8'h45, 1'b1, 16'h0001, 32'd13, 64'd3, 32'd3, 32'd3, 1'b1);
        send_msg(8'h41, 1'b0, 16'h0002, 32'hFFFF_FFFF, 64'd4, 32'd4, 32'd4, 1'b1);
        send_msg(8'h44, 1'b1, 16'h0002, 32'd0, 64'd5, 32'd5, 32'd5, 1'b0);
        wait_idle();

        // Early tlast on beat1, then a single-beat valid header
        send_beat({8'h41, 8'h00, 16'h0003, 32'd1}, 1'b0);
        send_beat(64'h1234, 1'b1);
        s_tvalid = 1'b0;
        tick();
        chk("early_tlast_err", 192'(err_cnt), 192'(1));
        send_beat({8'h44, 8'h00, 16'h0003, 32'd1}, 1'b1);
        s_tvalid = 1'b0;
        tick();
        chk("hdr_tlast_err", 192'(err_cnt), 192'(2));
        send_msg(8'h44, 1'b0, 16'h0003, 32'd1, 64'h77, 32'd9, 32'd10, 1'b0);
        wait_idle();
        chk("after_drop_err", 192'(err_cnt), 192'(2));

        // Bad type 4-beat and over-long 'E' message are discarded
        do_reset();
        send_beat({8'h5A, 8'h00, 16'h0004, 32'd50}, 1'b0);
        send_beat(64'h1, 1'b0);
        send_beat(64'h2, 1'b0);
        send_beat(64'h3, 1'b1);
        send_beat({8'h45, 8'h01, 16'h0004, 32'd51}, 1'b0);
        send_beat(64'h10, 1'b0);
        send_beat(64'h20, 1'b0);
        send_beat(64'h30, 1'b0);
        send_beat(64'h40, 1'b1);
        s_tvalid = 1'b0;
        tick();
        chk("discard_err", 192'(err_cnt), 192'(2));
        send_msg(8'h41, 1'b1, 16'h0004, 32'd100, 64'h0000_0001_0000_0000, 32'd300, 32'd42, 1'b0);
        wait_idle();
        chk("discard_after_err", 192'(err_cnt), 192'(2));

        // Reset while in PRICE
        send_beat({8'h41, 8'h01, 16'h0005, 32'd200}, 1'b0);
        s_tvalid = 1'b0;
        rst      = 1'b1;
        tick();
        chk("midrst_mvalid", 192'(m_valid),  192'(0));
        chk("midrst_tready", 192'(s_tready), 192'(0));
        chk("midrst_err",    192'(err_cnt),  192'(0));
        chk("midrst_fields", 192'({m_type, m_side, m_symbol, m_seq, m_price, m_qty, m_order_id, m_seq_gap}), 192'(0));
        rst = 1'b0;
        tick();
        send_msg(8'h45, 1'b0, 16'h0005, 32'd55, 64'hABCD, 32'd12, 32'd13, 1'b0);
        wait_idle();

        // Error counter saturates
        for (int i = 0; i < 9; i++) begin
            send_beat({8'h00, 8'h00, 16'h0000, 32'd0}, 1'b1);
        end
        s_tvalid = 1'b0;
        tick();
        chk("err_saturate", 192'(err_cnt), 192'(7));

        chk("all_delivered", 192'(rx_cnt), 192'(tx_cnt));
        chk("queue_empty",   192'(exp_q.size()), 192'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_msg_parser.md
AXIS_MSG_PARSER -- requirements
Module: axis_msg_parser

Interface
REQ-001 SHALL have parameter WIDTH, default 64, AXIS data width; any other value is rejected by an elaboration-time assertion.
REQ-002 SHALL have parameter ERR_W, default 16, error-counter width.
REQ-003 SHALL have one clock; reset is synchronous and active-high: port clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port s_tdata, input, WIDTH, upstream AXIS beat fed by the stream producer.
REQ-006 SHALL have port s_tvalid, input, 1, upstream beat valid.
REQ-007 SHALL have port s_tlast, input, 1, last beat of message.
REQ-008 SHALL have port s_tready, output, 1, parser accepts beat.
REQ-009 SHALL have port m_valid, output, 1, parsed record valid (feeds consumer stage).
REQ-010 SHALL have port m_ready, input, 1, downstream accepts record.
REQ-011 SHALL have port m_type, output, 8, message type byte.
REQ-012 SHALL have port m_side, output, 1, 0 = bid, 1 = ask.
REQ-013 SHALL have port m_symbol, output, 16, symbol id.
REQ-014 SHALL have port m_seq, output, 32, sequence number.
REQ-015 SHALL have port m_price, output, 64, signed fixed-point price.
REQ-016 SHALL have port m_qty, output, 32, quantity.
REQ-017 SHALL have port m_order_id, output, 32, order id.
REQ-018 SHALL have port m_seq_gap, output, 1, record's seq differs from expected.
REQ-019 SHALL have port err_cnt, output, ERR_W, saturating count of dropped messages.

Function
REQ-020 SHALL accept a beat only when s_tvalid && s_tready on a rising clk edge.
REQ-021 SHALL parse a 3-beat message: beat0 = type[63:56], side[48], symbol[47:32], seq[31:0]; beat1 = price[63:0]; beat2 = qty[63:32], order_id[31:0] with s_tlast=1.
REQ-022 SHALL implement FSM states HDR, PRICE, QTY, EMIT, DISCARD; reset state HDR.
REQ-023 SHALL transition HDR->PRICE on an accepted valid-type, tlast=0 header; PRICE->QTY on an accepted tlast=0 beat; QTY->EMIT on an accepted tlast=1 beat.
REQ-024 SHALL drive s_tready=1 in HDR, PRICE, QTY, DISCARD and 0 in EMIT.
REQ-025 SHALL assert m_valid in EMIT only, registered, first cycle after the beat2 handshake (latency 1), holding all m_* fields stable until m_valid && m_ready, then return to HDR.
REQ-026 SHALL treat valid types as 0x41 'A', 0x44 'D', 0x45 'E'; other types SHALL go HDR->DISCARD (or stay in HDR if that header has tlast=1) and increment err_cnt.
REQ-027 SHALL, on tlast=1 accepted in HDR (valid type) or PRICE, drop the message, increment err_cnt and go to HDR.
REQ-028 SHALL, on tlast=0 accepted in QTY, increment err_cnt and go to DISCARD.
REQ-029 SHALL in DISCARD consume beats, returning to HDR after the accepted tlast=1 beat, with no further err_cnt increment.
REQ-030 SHALL hold err_cnt at 2^ERR_W-1 on saturation.
REQ-031 SHALL compute m_seq_gap = seen_first && (seq != expected_seq) when entering EMIT; on each emitted record, set expected_seq = seq+1 modulo 2^32 (0xFFFFFFFF wraps to 0) and set seen_first.
REQ-032 SHALL not update expected_seq or seen_first for dropped messages.
REQ-033 SHALL sustain one record per 4 cycles when m_ready=1 and s_tvalid=1 continuously.

Reset
REQ-034 SHALL on rst: state=HDR, s_tready=0 during the reset cycle, m_valid=0, all m_* fields=0, err_cnt=0, expected_seq=0, seen_first=0.
REQ-035 SHALL abandon any partial message or pending record on rst mid-operation, without counting an error.

Structure
REQ-036 SHALL place the FSM state enum, the message-type constants, and a packed parsed-record struct in shared package fin_pkg.
REQ-037 SHALL instantiate one sub-module, sat_counter (parameter W, inputs clk, rst, inc; output count), for err_cnt.

Verification
REQ-038 SHALL verify: message type 0x41, side 1, symbol 0x0123, seq 5, price 0x0000_0000_0001_86A0, qty 100, id 7 -> one record with matching fields, m_seq_gap=0, err_cnt=0.
REQ-039 SHALL verify: m_ready held low 5 cycles after m_valid -> fields stable, s_tready=0 throughout, record delivered once.
REQ-040 SHALL verify: messages with seq 10, 11, 13 -> m_seq_gap = 0, 0, 1; seq 0xFFFFFFFF then 0 -> gap 0 on the second.
REQ-041 SHALL verify: tlast on beat1, then a valid message -> err_cnt=1, only the second message emitted.
REQ-042 SHALL verify: type 0x5A 4-beat message, and a 5-beat 'E' message -> both discarded through tlast, err_cnt=2, next message parsed correctly.
REQ-043 SHALL verify: rst asserted during PRICE -> all outputs zero next cycle, next full message parsed with m_seq_gap=0.
